// File: rtl/param_stack.sv
// param_stack: parameterised LIFO with occupancy count, random-access peek,
// sticky overflow/underflow flags, flush and push+pop replace-top.
// The read side is purely combinational from registered state, so only
// peek_idx has a combinational path to outputs.
module param_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic             clr_err,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    input  logic [AW-1:0]    peek_idx,
    output logic [WIDTH-1:0] peek_data,
    output logic             peek_valid,
    output logic [AW:0]      count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow,
    output logic             err
);

    // Storage and state. The array is not reset; every output is gated by
    // r_count so stale entries never become visible.
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic [AW:0]      w_count_next;
    logic             w_empty;
    logic             w_full;
    logic [AW-1:0]    w_top_idx;
    logic [AW-1:0]    w_peek_addr;
    logic             w_peek_valid;
    logic             w_wr_en;
    logic [AW-1:0]    w_wr_addr;
    logic             w_ovf_set;
    logic             w_udf_set;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == (AW+1)'(DEPTH));
    // Index of the top entry; only meaningful when not empty.
    assign w_top_idx = r_count[AW-1:0] - AW'(1);

    // A write happens for a non-full push, or for any push+pop (replace top,
    // or first entry when empty). Nothing is written in a reset or flush cycle.
    assign w_wr_en   = rst & ~flush & push & (pop | ~w_full);
    // Replace-top targets the current top; plain push (and push+pop on an
    // empty stack) targets the slot just above it.
    assign w_wr_addr = (pop && !w_empty) ? w_top_idx : r_count[AW-1:0];

    // Error events; flush suppresses them because push/pop are ignored then.
    assign w_ovf_set = ~flush & push & ~pop & w_full;
    assign w_udf_set = ~flush & pop & w_empty;

    // Next occupancy: flush clears, otherwise saturating push/pop rules.
    always_comb begin
        w_count_next = r_count;
        if (flush) begin
            w_count_next = '0;
        end else if (push && !pop) begin
            if (!w_full) begin
                w_count_next = r_count + (AW+1)'(1);
            end
        end else if (!push && pop) begin
            if (!w_empty) begin
                w_count_next = r_count - (AW+1)'(1);
            end
        end else if (push && pop && w_empty) begin
            w_count_next = (AW+1)'(1);
        end
    end

    // Pointer and sticky flags; a set event in the same cycle beats clr_err.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_count     <= w_count_next;
            r_overflow  <= w_ovf_set | (r_overflow & ~clr_err);
            r_underflow <= w_udf_set | (r_underflow & ~clr_err);
        end
    end

    // Data array write port.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= din;
        end
    end

    // Peek counts down from the top; address wraps harmlessly when invalid
    // because the data is gated by w_peek_valid.
    assign w_peek_valid = ({1'b0, peek_idx} < r_count);
    assign w_peek_addr  = w_top_idx - peek_idx;

    // Combinational read side, gated so an empty stack reads as zero.
    always_comb begin
        top       = '0;
        peek_data = '0;
        if (!w_empty) begin
            top = r_mem[w_top_idx];
        end
        if (w_peek_valid) begin
            peek_data = r_mem[w_peek_addr];
        end
    end

    assign peek_valid = w_peek_valid;
    assign count      = r_count;
    assign empty      = w_empty;
    assign full       = w_full;
    assign overflow   = r_overflow;
    assign underflow  = r_underflow;
    assign err        = r_overflow | r_underflow;

endmodule

// File: tb/tb_param_stack.sv
// Testbench for param_stack: a table of single-cycle vectors on an 8x4
// instance (expected state after each edge queued and compared one cycle
// later), plus a LIFO fill/drain sequence on a 32x16 instance.
module tb_param_stack;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit, 4-deep instance
    logic       rst8, push8, pop8, flush8, clr8;
    logic [7:0] din8, top8, peek8;
    logic [1:0] pidx8;
    logic       pv8, empty8, full8, ovf8, udf8, err8;
    logic [2:0] count8;

    // 32-bit, 16-deep instance
    logic        rst32, push32, pop32, flush32, clr32;
    logic [31:0] din32, top32, peek32;
    logic [3:0]  pidx32;
    logic        pv32, empty32, full32, ovf32, udf32, err32;
    logic [4:0]  count32;

    param_stack #(.WIDTH(8), .DEPTH(4)) u_dut8 (
        .clk(clk), .rst(rst8), .push(push8), .pop(pop8), .flush(flush8),
        .clr_err(clr8), .din(din8), .top(top8), .peek_idx(pidx8),
        .peek_data(peek8), .peek_valid(pv8), .count(count8), .empty(empty8),
        .full(full8), .overflow(ovf8), .underflow(udf8), .err(err8)
    );

    param_stack #(.WIDTH(32), .DEPTH(16)) u_dut32 (
        .clk(clk), .rst(rst32), .push(push32), .pop(pop32), .flush(flush32),
        .clr_err(clr32), .din(din32), .top(top32), .peek_idx(pidx32),
        .peek_data(peek32), .peek_valid(pv32), .count(count32), .empty(empty32),
        .full(full32), .overflow(ovf32), .underflow(udf32), .err(err32)
    );

    typedef struct {
        string      nm;
        logic       r, p, q, f, c;
        logic [7:0] d;
        logic [1:0] pi;
        int         ec;
        logic [7:0] et;
        logic [7:0] ep;
        logic       epv;
        logic       eo;
        logic       eu;
    } vec_t;

    vec_t        vecs[$];
    vec_t        exp_q[$];
    logic [31:0] model[$];
    int          tests_run = 0;
    int          tests_failed = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic r, input logic p, input logic q,
                       input logic f, input logic c, input logic [7:0] d,
                       input logic [1:0] pi, input int ec, input logic [7:0] et,
                       input logic [7:0] ep, input logic epv, input logic eo,
                       input logic eu);
        vec_t v;
        v.nm = nm; v.r = r; v.p = p; v.q = q; v.f = f; v.c = c; v.d = d; v.pi = pi;
        v.ec = ec; v.et = et; v.ep = ep; v.epv = epv; v.eo = eo; v.eu = eu;
        vecs.push_back(v);
    endtask

    initial begin
        vec_t e;
        rst8 = 1'b0; push8 = 1'b0; pop8 = 1'b0; flush8 = 1'b0; clr8 = 1'b0;
        din8 = 8'h00; pidx8 = 2'd0;
        rst32 = 1'b0; push32 = 1'b0; pop32 = 1'b0; flush32 = 1'b0; clr32 = 1'b0;
        din32 = 32'h0; pidx32 = 4'd0;

        //   name          rst p  q  f  c  din    pi  cnt top    peek   pv ovf udf
        add("reset",        0, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add("push11",       1, 1, 0, 0, 0, 8'h11, 0, 1, 8'h11, 8'h11, 1, 0, 0);
        add("push22",       1, 1, 0, 0, 0, 8'h22, 0, 2, 8'h22, 8'h22, 1, 0, 0);
        add("push33_pk2",   1, 1, 0, 0, 0, 8'h33, 2, 3, 8'h33, 8'h11, 1, 0, 0);
        add("idle_pk3",     1, 0, 0, 0, 0, 8'h00, 3, 3, 8'h33, 8'h00, 0, 0, 0);
        add("push44",       1, 1, 0, 0, 0, 8'h44, 0, 4, 8'h44, 8'h44, 1, 0, 0);
        add("push55_full",  1, 1, 0, 0, 0, 8'h55, 3, 4, 8'h44, 8'h11, 1, 1, 0);
        add("repl_full",    1, 1, 1, 0, 0, 8'hAA, 1, 4, 8'hAA, 8'h33, 1, 1, 0);
        add("pop_expose",   1, 0, 1, 0, 0, 8'h00, 0, 3, 8'h33, 8'h33, 1, 1, 0);
        add("flush_push",   1, 1, 0, 1, 0, 8'h99, 0, 0, 8'h00, 8'h00, 0, 1, 0);
        add("flush_pop",    1, 0, 1, 1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1, 0);
        add("push77",       1, 1, 0, 0, 0, 8'h77, 0, 1, 8'h77, 8'h77, 1, 1, 0);
        add("clr_ovf",      1, 0, 0, 0, 1, 8'h00, 0, 1, 8'h77, 8'h77, 1, 0, 0);
        add("pop_last",     1, 0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add("pop_empty",    1, 0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1);
        add("pop_clr",      1, 0, 1, 0, 1, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1);
        add("clr_udf",      1, 0, 0, 0, 1, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add("pp_empty",     1, 1, 1, 0, 0, 8'h5A, 0, 1, 8'h5A, 8'h5A, 1, 0, 1);
        add("push66",       1, 1, 0, 0, 0, 8'h66, 1, 2, 8'h66, 8'h5A, 1, 0, 1);
        add("rst_push",     0, 1, 0, 0, 0, 8'h12, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add("push21",       1, 1, 0, 0, 0, 8'h21, 0, 1, 8'h21, 8'h21, 1, 0, 0);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            rst8 = vecs[i].r; push8 = vecs[i].p; pop8 = vecs[i].q;
            flush8 = vecs[i].f; clr8 = vecs[i].c; din8 = vecs[i].d;
            pidx8 = vecs[i].pi;
            exp_q.push_back(vecs[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            check({e.nm, ".count"}, 32'(count8), 32'(e.ec));
            check({e.nm, ".top"}, 32'(top8), 32'(e.et));
            check({e.nm, ".peek_data"}, 32'(peek8), 32'(e.ep));
            check({e.nm, ".peek_valid"}, 32'(pv8), 32'(e.epv));
            check({e.nm, ".empty"}, 32'(empty8), 32'(e.ec == 0));
            check({e.nm, ".full"}, 32'(full8), 32'(e.ec == 4));
            check({e.nm, ".overflow"}, 32'(ovf8), 32'(e.eo));
            check({e.nm, ".underflow"}, 32'(udf8), 32'(e.eu));
            check({e.nm, ".err"}, 32'(err8), 32'(e.eo | e.eu));
            $display("[TB] w8 %-12s count=%0d top=%02h peek=%02h pv=%0b ovf=%0b udf=%0b",
                     e.nm, count8, top8, peek8, pv8, ovf8, udf8);
        end
        rst8 = 1'b1; push8 = 1'b0; pop8 = 1'b0; flush8 = 1'b0; clr8 = 1'b0;

        // 32x16: reset state, fill with random words, then drain in LIFO order
        check("w32_reset.count", 32'(count32), 32'd0);
        check("w32_reset.top", top32, 32'd0);
        check("w32_reset.empty", 32'(empty32), 32'd1);
        rst32 = 1'b1;
        push32 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            din32 = $urandom;
            model.push_back(din32);
            @(negedge clk);
            check($sformatf("w32_push%0d.top", i), top32, model[$]);
            check($sformatf("w32_push%0d.count", i), 32'(count32), 32'(i + 1));
            $display("[TB] w32 push %0d din=%08h count=%0d top=%08h", i, din32, count32, top32);
        end
        push32 = 1'b0;
        pidx32 = 4'd15;
        #1;
        check("w32_full", 32'(full32), 32'd1);
        check("w32_peek15", peek32, model[0]);
        check("w32_peek15_valid", 32'(pv32), 32'd1);
        pidx32 = 4'd0;
        pop32 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("w32_pop%0d.top", i), top32, model[$]);
            $display("[TB] w32 pop %0d top=%08h count=%0d", i, top32, count32);
            void'(model.pop_back());
            @(negedge clk);
        end
        pop32 = 1'b0;
        check("w32_drained.count", 32'(count32), 32'd0);
        check("w32_drained.empty", 32'(empty32), 32'd1);
        check("w32_drained.top", top32, 32'd0);
        check("w32_drained.err", 32'(err32), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/param_stack.md
Name: param_stack

Overview:
Parametrised hardware LIFO. It is the successor to the fixed 8-bit call/return stack in the pumpeds CPU.
- Generalised in data width and depth.
- Adds full/empty status, an occupancy count, and a random-access peek port.
- Adds sticky overflow/underflow error flags (for the HALT ERROR path), flush, and push+pop replace-top.
- Sits beside the register file. CALL/PUSH drive push, RET/POP drive pop, and top feeds the op_mux RET/RAM_2 inputs.

Parameters:
WIDTH, 32, data word width in bits (>=1).
DEPTH, 16, number of entries; power of two, >=2.
AW, log2(DEPTH), derived localparam, not overridable; index width.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-low reset (sampled on clk rising edge, asserted when 0).
push  input  1  write din onto stack this cycle.
pop  input  1  remove top entry this cycle.
flush  input  1  empty the stack this cycle.
clr_err  input  1  clear the sticky overflow/underflow flags.
din  input  WIDTH  data to push.
top  output  WIDTH  current top-of-stack; 0 when empty.
peek_idx  input  AW  depth index to read; 0 = top, 1 = next below, ...
peek_data  output  WIDTH  entry at peek_idx; 0 when peek_valid=0.
peek_valid  output  1  peek_idx < count.
count  output  AW+1  number of valid entries, 0..DEPTH.
empty  output  1  count==0.
full  output  1  count==DEPTH.
overflow  output  1  sticky: a push was dropped because the stack was full.
underflow  output  1  sticky: a pop was issued while empty.
err  output  1  overflow | underflow.

Behaviour:
- Storage: DEPTH x WIDTH register array with a stack pointer sp = count. Entry i (0-based from bottom) is valid for i < count.
- Reset (rst=0 at edge): count=0, overflow=0, underflow=0. Array contents are not reset; all outputs are gated so none shows stale data. After reset: top=0, peek_data=0, peek_valid=0, empty=1, full=0, err=0.
- Read side is fully combinational from the current state:
  - top = mem[count-1] when count>0, else 0.
  - peek_data = mem[count-1-peek_idx] when peek_valid, else 0.
- Write side takes one cycle. A push is visible on top in the cycle after the edge. A pop exposes the previous entry on top in the cycle after the edge.
- Priority per edge: rst > flush > push/pop.
- flush=1: count<=0. push and pop are ignored in that cycle and error flags are unchanged. clr_err is still honoured.
- push=1, pop=0:
  - Not full: mem[count]<=din, count<=count+1.
  - Full: no change to storage or count; overflow<=1.
- push=0, pop=1:
  - Not empty: count<=count-1. The data stays in the array but is no longer visible.
  - Empty: count stays 0; underflow<=1.
- push=1, pop=1:
  - Not empty: replace top, i.e. mem[count-1]<=din with count unchanged. This holds even when full; no overflow.
  - Empty: treated as a push (mem[0]<=din, count<=1) and underflow<=1.
- clr_err=1: overflow<=0, underflow<=0. If an error event occurs in the same cycle, the set wins and the flag reads 1 next cycle.
- count never wraps; it saturates at 0 and DEPTH per the rules above.
- Mid-operation reset: any push/pop in the reset cycle is discarded.
- No combinational path from push/pop/din to any output. peek_idx -> peek_data/peek_valid is the only combinational input-to-output path.

Test Plan:
1. WIDTH=8, DEPTH=4. Reset, then push 0x11,0x22,0x33 on consecutive cycles -> count=3, top=0x33; peek_idx=2 gives peek_data=0x11, peek_valid=1; peek_idx=3 gives peek_valid=0, peek_data=0.
2. Fill to 4 entries (add 0x44), then push 0x55 -> full=1, count=4, top=0x44, overflow=1, err=1. Then clr_err -> overflow=0 next cycle.
3. From empty, pop -> count=0, top=0, underflow=1. Then pop+clr_err in the same cycle -> underflow stays 1.
4. Full stack [0x11..0x44], push+pop with din=0xAA -> count=4, top=0xAA, peek_idx=1 gives 0x33, no overflow. From empty, push+pop with din=0x5A -> count=1, top=0x5A, underflow=1.
5. Three entries, assert flush together with push of 0x99 -> count=0, empty=1, top=0, flags unchanged. Next push of 0x77 -> top=0x77, count=1.
6. Push 2 entries with an error flag set, then drive rst=0 for one edge while also asserting push -> count=0, all flags 0, top=0. Repeat at WIDTH=32, DEPTH=16: 16 pushes, then 16 pops returning values in LIFO order, ending with empty=1 and err=0.
